// File: rtl/bcd_run_ctrl.sv
// Run controller for a cascade of BCD digit counters: start/stop/clear command
// handling, a clock prescaler, carry chaining, target stop and free-run overflow.
module bcd_run_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10,
  parameter int PS_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                running,
  output logic                done,
  output logic                overflow
);

  localparam int CW = 4 * DIGITS;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_nx;
  logic [PS_W-1:0] ps, ps_nx;
  logic [CW-1:0]   count_nx, count_inc;
  logic            done_nx, ovf_nx;
  logic            carry;
  logic [3:0]      dig;

  assign tick = (state == RUN) && (ps == PS_LAST);

  // Ripple BCD increment; the carry out of the top digit means every digit was 9.
  always_comb begin
    count_inc = '0;
    carry     = 1'b1;
    dig       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc[4*i +: 4] = dig;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ps_nx    = ps;
    count_nx = count;
    done_nx  = 1'b0;
    ovf_nx   = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      ps_nx    = '0;
      count_nx = '0;
    end else begin
      case (state)
        IDLE:  if (start && !stop) state_nx = RUN;
        RUN: begin
          if (tick) begin
            ps_nx    = '0;
            count_nx = count_inc;
            if ((target != '0) && (count_inc == target)) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else if (carry) begin
              ovf_nx = 1'b1;
            end
          end else begin
            ps_nx = ps + PS_W'(1);
          end
          // A stop still lets this edge's tick land; reaching target takes precedence.
          if (stop && (state_nx == RUN)) state_nx = PAUSE;
        end
        PAUSE: if (start && !stop) state_nx = RUN;
        DONE:  state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ps       <= '0;
      count    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      ps       <= ps_nx;
      count    <= count_nx;
      running  <= (state_nx == RUN);
      done     <= done_nx;
      overflow <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Bench for bcd_run_ctrl: a 4-digit/prescale-3 instance for run, target, carry,
// pause and priority cases, and a 2-digit/prescale-1 instance for overflow.
module tb_bcd_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 0, stop_a = 0, clear_a = 0;
  logic [15:0] target_a = '0;
  logic [15:0] count_a;
  logic        tick_a, running_a, done_a, overflow_a;

  logic        start_b = 0, stop_b = 0, clear_b = 0;
  logic [7:0]  target_b = '0;
  logic [7:0]  count_b;
  logic        tick_b, running_b, done_b, overflow_b;

  bcd_run_ctrl #(.DIGITS(4), .PRESCALE(3), .PS_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .clear(clear_a),
    .target(target_a), .count(count_a), .tick(tick_a), .running(running_a),
    .done(done_a), .overflow(overflow_a)
  );

  bcd_run_ctrl #(.DIGITS(2), .PRESCALE(1), .PS_W(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .clear(clear_b),
    .target(target_b), .count(count_b), .tick(tick_b), .running(running_b),
    .done(done_b), .overflow(overflow_b)
  );

  // Expected words after each tick edge: {tick, running, overflow, done, count}
  logic [19:0] exp_a_q[$];
  logic [11:0] exp_b_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  logic ptick_a = 1'b0;
  logic ptick_b = 1'b0;
  int n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] word_a(input logic tk, input logic run, input logic ovf,
                                         input logic dn, input logic [15:0] c);
    return {tk, run, ovf, dn, c};
  endfunction

  function automatic logic [11:0] word_b(input logic tk, input logic run, input logic ovf,
                                         input logic dn, input logic [7:0] c);
    return {tk, run, ovf, dn, c};
  endfunction

  // Monitors: after every tick edge pop and compare; otherwise done/overflow must be low.
  always @(negedge clk) begin
    if (!rst) begin
      ptick_a <= 1'b0;
    end else begin
      if (ptick_a) begin
        if (exp_a_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL a_unexpected_tick: count %h with no expected entry", count_a);
        end else begin
          check("a_after_tick", 32'({tick_a, running_a, overflow_a, done_a, count_a}),
                32'(exp_a_q.pop_front()));
        end
      end else begin
        check("a_no_pulse", 32'({done_a, overflow_a}), 32'd0);
      end
      ptick_a <= tick_a;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      ptick_b <= 1'b0;
    end else begin
      if (ptick_b) begin
        if (exp_b_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL b_unexpected_tick: count %h with no expected entry", count_b);
        end else begin
          check("b_after_tick", 32'({tick_b, running_b, overflow_b, done_b, count_b}),
                32'(exp_b_q.pop_front()));
        end
      end else begin
        check("b_no_pulse", 32'({done_b, overflow_b}), 32'd0);
      end
      ptick_b <= tick_b;
    end
  end

  task automatic wait_a(input logic [15:0] v, input int budget, input string name, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (count_a !== v) begin
      if (cyc >= budget) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout, count %h expected %h", name, count_a, v);
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_b(input logic [7:0] v, input int budget, input string name, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (count_b !== v) begin
      if (cyc >= budget) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout, count %h expected %h", name, count_b, v);
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_clear_a();
    @(posedge clk); #1 clear_a = 1'b1;
    @(posedge clk); #1 clear_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_fail + 1);
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_a", 32'({count_a, tick_a, running_a, done_a, overflow_a}), 32'd0);
    check("reset_b", 32'({count_b, tick_b, running_b, done_b, overflow_b}), 32'd0);

    // Async reset mid-run at count 5
    for (int k = 1; k <= 5; k++) exp_a_q.push_back(word_a(0, 1, 0, 0, bcd(k)));
    pulse_start_a();
    wait_a(16'h0005, 40, "a_reach_5", n);
    #2 rst = 1'b0;
    #1 check("async_reset", 32'({count_a, tick_a, running_a, done_a, overflow_a}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", 32'({count_a, running_a, tick_a}), 32'd0);
    check("a_queue_after_reset", 32'(exp_a_q.size()), 32'd0);

    // Target stop at 0x0012
    target_a = 16'h0012;
    for (int k = 1; k <= 11; k++) exp_a_q.push_back(word_a(0, 1, 0, 0, bcd(k)));
    exp_a_q.push_back(word_a(0, 0, 0, 1, 16'h0012));
    pulse_start_a();
    wait_a(16'h0001, 10, "a_first_tick", n);
    check("first_tick_latency", 32'(n), 32'd3);
    wait_a(16'h0012, 60, "a_reach_target", n);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 start_a = (i < 6);
      @(negedge clk);
      check("done_hold", 32'({count_a, running_a, tick_a}), 32'({16'h0012, 2'b00}));
    end
    start_a = 1'b0;
    pulse_clear_a();
    target_a = '0;
    @(negedge clk);
    check("clear_from_done", 32'({count_a, running_a}), 32'd0);
    check("a_queue_after_target", 32'(exp_a_q.size()), 32'd0);

    // Carry chain through 0x0099 and 0x0999, free-run
    for (int k = 1; k <= 1000; k++) exp_a_q.push_back(word_a(0, 1, 0, 0, bcd(k)));
    pulse_start_a();
    wait_a(16'h1000, 3100, "a_reach_1000", n);

    // Stop one cycle after the tick, freeze, then stop+start in PAUSE
    #1 stop_a = 1'b1;
    @(posedge clk); #1 stop_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_frozen", 32'({count_a, tick_a, running_a}), 32'({16'h1000, 2'b00}));
    end
    @(posedge clk); #1 begin start_a = 1'b1; stop_a = 1'b1; end
    @(posedge clk); #1 begin start_a = 1'b0; stop_a = 1'b0; end
    @(negedge clk);
    check("stop_beats_start", 32'({count_a, running_a}), 32'({16'h1000, 1'b0}));
    exp_a_q.push_back(word_a(0, 1, 0, 0, 16'h1001));
    pulse_start_a();
    wait_a(16'h1001, 10, "a_resume_tick", n);
    check("resume_latency", 32'(n), 32'd2);
    #1 clear_a = 1'b1;
    @(posedge clk); #1 clear_a = 1'b0;
    @(negedge clk);
    check("clear_from_run", 32'({count_a, running_a}), 32'd0);

    // clear+start together in RUN at 0x0042
    for (int k = 1; k <= 42; k++) exp_a_q.push_back(word_a(0, 1, 0, 0, bcd(k)));
    pulse_start_a();
    wait_a(16'h0042, 200, "a_reach_42", n);
    #1 begin clear_a = 1'b1; start_a = 1'b1; end
    @(posedge clk); #1 begin clear_a = 1'b0; start_a = 1'b0; end
    @(negedge clk);
    check("clear_beats_start", 32'({count_a, running_a, tick_a}), 32'd0);
    repeat (4) @(negedge clk);
    check("idle_after_clear", 32'({count_a, running_a}), 32'd0);
    check("a_queue_end", 32'(exp_a_q.size()), 32'd0);

    // Free-run overflow on the 2-digit prescale-1 instance
    for (int k = 1; k <= 99; k++) exp_b_q.push_back(word_b(1, 1, 0, 0, 8'(bcd(k))));
    exp_b_q.push_back(word_b(1, 1, 1, 0, 8'h00));
    exp_b_q.push_back(word_b(1, 1, 0, 0, 8'h01));
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    wait_b(8'h99, 200, "b_reach_99", n);
    wait_b(8'h00, 3, "b_roll", n);
    wait_b(8'h01, 3, "b_after_roll", n);
    // stop coincides with a tick: the increment lands, then PAUSE
    #1 stop_b = 1'b1;
    exp_b_q.push_back(word_b(0, 0, 0, 0, 8'h02));
    @(posedge clk); #1 stop_b = 1'b0;
    repeat (3) @(negedge clk);
    check("b_paused", 32'({count_b, running_b, tick_b}), 32'({8'h02, 2'b00}));
    @(posedge clk); #1 clear_b = 1'b1;
    @(posedge clk); #1 clear_b = 1'b0;
    @(negedge clk);
    check("b_clear", 32'({count_b, running_b}), 32'd0);
    check("b_queue_end", 32'(exp_b_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_run_ctrl.md
Name: bcd_run_ctrl

Overview:
- Run controller for a cascade of decade (BCD 0-9) digit counters.
- Sequences counting with a start/stop/clear command interface and a programmable clock prescaler.
- Chains digit carries and stops at a programmable BCD target, or free-runs with an overflow flag.
- Sits between the control logic (buttons, CPU regs) and the display/readout path that consumes the BCD count.

Parameters:
- DIGITS, 4: number of cascaded BCD digits; count width = 4*DIGITS.
- PRESCALE, 10: clk cycles per count tick while running; legal range >= 1.
- PS_W, 16: prescaler counter width; must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: level command; begin or resume counting.
- stop, input, 1: level command; pause counting.
- clear, input, 1: level command; zero count and prescaler, return to IDLE.
- target, input, 4*DIGITS: BCD stop value; all-zero selects free-run mode.
- count, output, 4*DIGITS: BCD count, digit 0 in bits [3:0].
- tick, output, 1: one-cycle pulse on each count increment.
- running, output, 1: high in RUN state.
- done, output, 1: one-cycle pulse when count reaches target.
- overflow, output, 1: one-cycle pulse on all-9s to all-0s roll in free-run mode.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, prescaler=0, tick/running/done/overflow=0. Reset mid-run aborts immediately; no done or overflow is emitted.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority: clear > stop > start.
- clear, from any state: next edge gives count=0, prescaler=0, state=IDLE.
- IDLE: start -> RUN.
- RUN: stop -> PAUSE.
- PAUSE: start -> RUN.
- DONE: start and stop are ignored; only clear leaves DONE.
- Prescaler: increments only in RUN. At value PRESCALE-1 it wraps to 0 and tick=1 for that cycle; tick is combinational from registered state/prescaler and only asserts in RUN.
- PAUSE holds the prescaler value, so the partial interval is preserved and RUN resumes without losing cycles.
- First tick comes PRESCALE cycles after the edge that enters RUN from IDLE. PRESCALE=1 gives a tick every RUN cycle.
- Digit cascade, on a tick edge:
  - digit0 increments (9 wraps to 0).
  - digit i increments/wraps only if all digits below it are 9.
  - No digit leaves 0-9.
- Target match: compare the next-count value to target on the tick edge. If equal and target != 0, on the same edge state=DONE, count=target and done register=1. done is visible for exactly one cycle, coincident with the first cycle that count==target. count holds thereafter.
- Targets containing any nibble > 9 never match, so the block behaves as free-run without overflow suppression.
- Free-run (target=0): when all digits are 9 and a tick occurs, count becomes 0. overflow is registered high for one cycle and the state stays RUN.
- In target mode the all-9s roll also raises overflow. This only happens if target is not reachable.
- running = (state==RUN), registered.
- Simultaneous start+stop in IDLE/PAUSE: stop wins, so there is no transition from IDLE and PAUSE stays in PAUSE.
- A stop in the same cycle as a tick: the tick increment still occurs on that edge and the state goes to PAUSE.

Test Plan:
- Reset (DIGITS=4, PRESCALE=3): run to count=0x0005, drive rst=0 between edges -> count=0x0000, running=0 immediately; no done/overflow; after release, IDLE holds with start=0.
- Target stop (target=0x0012): pulse start -> first tick 3 cycles after RUN entry; count reaches 0x0012 at tick 12 (36 cycles). done=1 for exactly one cycle; running=0; count stays 0x0012 for 20 more cycles; start is ignored until clear.
- Carry chain (target=0): run to 0x0099 -> next tick gives 0x0100; at 0x0999 -> 0x1000; tick is one cycle wide each time.
- Overflow (DIGITS=2, PRESCALE=1, target=0): 99 ticks reach 0x99 -> next edge gives 0x00 with overflow=1 for one cycle; running stays 1 and count continues to 0x01.
- Pause (PRESCALE=3): stop one cycle after a tick -> no tick and count frozen for 10 cycles; start again -> next tick arrives 2 cycles after RUN re-entry (partial prescale preserved).
- Priority: clear+start together in RUN at count=0x0042 -> count=0, IDLE, running=0. stop+start together in PAUSE -> remains PAUSE.
